alu_arb_cp4: RTL and testbench

- Round-robin arbiter and sequencer that shares the single combinational ALU (alu_cp4) among NUM_REQ requesters, e.g. the execute stage and a CSR/address-generation helper.
- Accepts one operation per grant through a valid/ready handshake and registers its operands.
- Drives the ALU for one cycle, captures the result and zero flag, and returns them tagged with the requester ID over a valid/ready response channel.
- Sits between the requesters and alu_cp4 inside the cp4 core.

---
 rtl/alu_cp4_pkg.sv | 24 ++
 rtl/rr_pick_cp4.sv | 26 ++
 rtl/alu_arb_cp4.sv | 110 +++++++++++
 tb/tb_alu_arb_cp4.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cp4_pkg.sv
// Shared cp4 ALU definitions: opcode constants, arbiter state encoding, default width.
package alu_cp4_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [3:0] OP_ADD    = 4'b0000;
   localparam logic [3:0] OP_SUB    = 4'b1000;
   localparam logic [3:0] OP_AND    = 4'b0111;
   localparam logic [3:0] OP_OR     = 4'b0110;
   localparam logic [3:0] OP_XOR    = 4'b0100;
   localparam logic [3:0] OP_SLL    = 4'b0001;
   localparam logic [3:0] OP_SRL    = 4'b0101;
   localparam logic [3:0] OP_SRA    = 4'b1101;
   localparam logic [3:0] OP_SLT    = 4'b0010;
   localparam logic [3:0] OP_SLTU   = 4'b0011;
   localparam logic [3:0] OP_PASS_B = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_pick_cp4.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick_cp4 #(
   parameter int N   = 2,
   parameter int IDW = 1
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   gnt_oh,
   output logic [IDW-1:0] gnt_idx,
   output logic           any_valid
);

   always_comb begin
      gnt_oh    = '0;
      gnt_idx   = '0;
      any_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!any_valid && req[(int'(ptr) + k) % N]) begin
            gnt_oh[(int'(ptr) + k) % N] = 1'b1;
            gnt_idx   = IDW'((int'(ptr) + k) % N);
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_arb_cp4.sv
// Round-robin arbiter/sequencer sharing one combinational ALU among NUM_REQ requesters.
// Optional macro ALU_ARB_FAST_EN: grant directly out of RESP when the response is accepted.
//
// state | meaning
// IDLE  | pick a requester, accept its operation
// EXEC  | operand registers drive the ALU, result captured at the edge
// RESP  | response held until rsp_ready
module alu_arb_cp4 import alu_cp4_pkg::*; #(
   parameter int NUM_REQ = 2,
   parameter int XLEN    = XLEN_DEF,
   parameter int ID_W    = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*XLEN-1:0] req_a,
   input  logic [NUM_REQ*XLEN-1:0] req_b,
   input  logic [NUM_REQ*4-1:0]    req_op,
   output logic [XLEN-1:0]         alu_a,
   output logic [XLEN-1:0]         alu_b,
   output logic [3:0]              alu_op,
   input  logic [XLEN-1:0]         alu_rd,
   input  logic                    alu_zero,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [XLEN-1:0]         rsp_data,
   output logic                    rsp_zero
);

   arb_state_e        state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [XLEN-1:0]   a_q, b_q, data_q;
   logic [3:0]        op_q;
   logic [ID_W-1:0]   id_q;
   logic              zero_q;

   logic [NUM_REQ-1:0] gnt_oh;
   logic [ID_W-1:0]    gnt_idx;
   logic               any_valid;
   logic               grant_en;
   logic               hs;

   rr_pick_cp4 #(.N(NUM_REQ), .IDW(ID_W)) u_pick (
      .req       (req_valid),
      .ptr       (rr_ptr_q),
      .gnt_oh    (gnt_oh),
      .gnt_idx   (gnt_idx),
      .any_valid (any_valid)
   );

   // Gating with rst keeps req_ready low while reset is asserted.
`ifdef ALU_ARB_FAST_EN
   assign grant_en = !rst && ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready));
`else
   assign grant_en = !rst && (state_q == ST_IDLE);
`endif
   assign hs = grant_en && any_valid;

   assign rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         id_q     <= '0;
         data_q   <= '0;
         zero_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (hs) begin
            a_q      <= req_a[gnt_idx*XLEN +: XLEN];
            b_q      <= req_b[gnt_idx*XLEN +: XLEN];
            op_q     <= req_op[gnt_idx*4 +: 4];
            id_q     <= gnt_idx;
            rr_ptr_q <= rr_ptr_d;
         end
         if (state_q == ST_EXEC) begin
            data_q <= alu_rd;
            zero_q <= alu_zero;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (hs) state_d = ST_EXEC;
         ST_EXEC: state_d = ST_RESP;
         ST_RESP: if (rsp_ready) state_d = hs ? ST_EXEC : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready = grant_en ? gnt_oh : '0;
      rsp_valid = (state_q == ST_RESP);
      alu_a     = a_q;
      alu_b     = b_q;
      alu_op    = op_q;
      rsp_id    = id_q;
      rsp_data  = data_q;
      rsp_zero  = zero_q;
   end

endmodule

// File: tb/tb_alu_arb_cp4.sv
// Directed, table-driven bench for alu_arb_cp4 with a behavioural ALU stand-in.
module tb_alu_arb_cp4;
   import alu_cp4_pkg::*;

`ifdef ALU_ARB_FAST_EN
   localparam int PERIOD = 2;
`else
   localparam int PERIOD = 3;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [63:0] req_a, req_b;
   logic [7:0]  req_op;
   logic [31:0] alu_a, alu_b, alu_rd;
   logic [3:0]  alu_op;
   logic        alu_zero;
   logic        rsp_valid, rsp_ready, rsp_zero;
   logic [0:0]  rsp_id;
   logic [31:0] rsp_data;

   int nchecks = 0;
   int nerrors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_arb_cp4 #(.NUM_REQ(2), .XLEN(32), .ID_W(1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_rd(alu_rd), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_zero(rsp_zero)
   );

   always_comb begin
      alu_rd = '0;
      case (alu_op)
         OP_ADD:    alu_rd = alu_a + alu_b;
         OP_SUB:    alu_rd = alu_a - alu_b;
         OP_AND:    alu_rd = alu_a & alu_b;
         OP_OR:     alu_rd = alu_a | alu_b;
         OP_XOR:    alu_rd = alu_a ^ alu_b;
         OP_SLL:    alu_rd = alu_a << alu_b[4:0];
         OP_SRL:    alu_rd = alu_a >> alu_b[4:0];
         OP_SRA:    alu_rd = $signed(alu_a) >>> alu_b[4:0];
         OP_SLT:    alu_rd = {31'd0, $signed(alu_a) < $signed(alu_b)};
         OP_SLTU:   alu_rd = {31'd0, alu_a < alu_b};
         OP_PASS_B: alu_rd = alu_b;
         default:   alu_rd = '0;
      endcase
      alu_zero = (alu_rd == '0);
   end

   typedef struct {
      int          id;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [31:0] exp_d;
      logic        exp_z;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op);
      req_a[id*32 +: 32] = a;
      req_b[id*32 +: 32] = b;
      req_op[id*4 +: 4]  = op;
   endtask

   // Called at a negedge right after a handshake edge; returns cycles to rsp_valid.
   task automatic wait_rsp(input int start, output int lat);
      lat = start;
      for (int t = 0; t < 20; t++) begin
         if (rsp_valid) break;
         @(negedge clk); #1;
         lat++;
      end
      if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
   endtask

   task automatic consume();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
   endtask

   task automatic run_single(input vec_t v);
      int lat;
      @(negedge clk);
      set_req(v.id, v.a, v.b, v.op);
      req_valid = 2'b01 << v.id;
      #1;
      chk("req_ready_grant", {30'd0, req_ready}, 32'd1 << v.id);
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      wait_rsp(1, lat);
      chk("latency", lat, 32'd2);
      chk("rsp_id", {31'd0, rsp_id}, v.id);
      chk("rsp_data", rsp_data, v.exp_d);
      chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, v.exp_z});
      consume();
   endtask

   initial begin
      int lat, nrsp, ngnt, last_cyc;
      vecs[0] = '{0, 32'd5,          32'd7,          OP_ADD,    32'd12,         1'b0};
      vecs[1] = '{1, 32'h10,         32'h10,         OP_SUB,    32'd0,          1'b1};
      vecs[2] = '{0, 32'hF0F0,       32'h0FF0,       OP_AND,    32'h00F0,       1'b0};
      vecs[3] = '{1, 32'h8000_0000,  32'd4,          OP_SRA,    32'hF800_0000,  1'b0};
      vecs[4] = '{0, 32'd1,          32'd31,         OP_SLL,    32'h8000_0000,  1'b0};
      vecs[5] = '{1, 32'hFFFF_FFFF,  32'd1,          OP_SLT,    32'd1,          1'b0};
      vecs[6] = '{0, 32'hFFFF_FFFF,  32'd1,          OP_SLTU,   32'd0,          1'b1};
      vecs[7] = '{0, 32'h1234,       32'h5678,       4'b1010,   32'd0,          1'b1};
      vecs[8] = '{1, 32'd3,          32'hAA,         OP_PASS_B, 32'hAA,         1'b0};

      rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      req_valid = 2'b11;
      #1;
      chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
      req_valid = 2'b00;
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) run_single(vecs[i]);

      // Both requesting continuously: grants alternate starting from requester 0.
      @(negedge clk);
      set_req(0, 32'h0, 32'hAA, OP_PASS_B);
      set_req(1, 32'hF0, 32'h0F, OP_XOR);
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      nrsp = 0; ngnt = 0; last_cyc = 0;
      for (int t = 0; t < 40 && nrsp < 4; t++) begin
         #1;
         if (req_ready != 2'b00) begin
            chk("alt_grant", {30'd0, req_ready}, (ngnt % 2 == 0) ? 32'd1 : 32'd2);
            ngnt++;
         end
         if (rsp_valid) begin
            chk("alt_id", {31'd0, rsp_id}, nrsp % 2);
            chk("alt_data", rsp_data, (nrsp % 2 == 0) ? 32'hAA : 32'hFF);
            if (nrsp > 0) chk("alt_period", cyc - last_cyc, PERIOD);
            last_cyc = cyc;
            nrsp++;
         end
         @(negedge clk);
      end
      chk("alt_count", nrsp, 32'd4);
      req_valid = 2'b00;
      repeat (5) @(negedge clk);
      rsp_ready = 1'b0;

      // Stalled response: outputs hold, no grant to the waiting requester.
      @(negedge clk);
      set_req(0, 32'd1, 32'd2, OP_ADD);
      set_req(1, 32'd2, 32'd2, OP_ADD);
      req_valid = 2'b01;
      #1;
      chk("stall_grant0", {30'd0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid = 2'b10;
      #1;
      wait_rsp(1, lat);
      for (int s = 0; s < 5; s++) begin
         chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
         chk("stall_data", rsp_data, 32'd3);
         chk("stall_ready", {30'd0, req_ready}, 32'd0);
         @(negedge clk); #1;
      end
      rsp_ready = 1'b1;
      for (int t = 0; t < 10 && req_ready == 2'b00; t++) begin
         #1;
         if (req_ready == 2'b00) @(negedge clk);
      end
      chk("stall_grant1", {30'd0, req_ready}, 32'd2);
      @(negedge clk);
      req_valid = 2'b00;
      rsp_ready = 1'b0;
      #1;
      wait_rsp(1, lat);
      chk("stall_rsp1_id", {31'd0, rsp_id}, 32'd1);
      chk("stall_rsp1_data", rsp_data, 32'd4);
      consume();

      // Reset during EXEC discards the op and restarts round-robin at 0.
      @(negedge clk);
      set_req(0, 32'h8000_0000, 32'd4, OP_SRA);
      req_valid = 2'b01;
      #1;
      chk("rst_mid_grant", {30'd0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid = 2'b00;
      rst = 1'b1;
      #1;
      chk("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_mid_alu_a", alu_a, 32'd0);
      chk("rst_mid_alu_b", alu_b, 32'd0);
      chk("rst_mid_alu_op", {28'd0, alu_op}, 32'd0);
      chk("rst_mid_data", rsp_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int s = 0; s < 4; s++) begin
         @(negedge clk); #1;
         chk("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      end
      set_req(0, 32'd3, 32'd4, OP_ADD);
      set_req(1, 32'd9, 32'd2, OP_SUB);
      req_valid = 2'b11;
      #1;
      chk("rst_rr_ptr0", {30'd0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      wait_rsp(1, lat);
      chk("rst_after_lat", lat, 32'd2);
      chk("rst_after_id", {31'd0, rsp_id}, 32'd0);
      chk("rst_after_data", rsp_data, 32'd7);
      consume();

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
